mesh_term_fifo_bank: RTL

MESH_TERM_FIFO_BANK -- requirements
Module: mesh_term_fifo_bank

---
 rtl/mesh_term_fifo_bank.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mesh_term_fifo_bank.sv
// Bank of independent show-ahead FIFOs, one per mesh terminal, with per-channel drop counters.
// Optional MESH_DST_CHECK_EN: drop pushes whose header addresses a non-existent row/column.
module mesh_term_fifo_bank #(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMNS    = 4,
  parameter int unsigned PAKG_SIZE  = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [7:0]  BDCST      = 8'hFF,
  localparam int unsigned NUM_CH    = 2*ROWS + 2*COLUMNS,
  localparam int unsigned CW        = $clog2(FIFO_DEPTH+1)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_CH-1:0]           push,
  input  logic [NUM_CH*PAKG_SIZE-1:0] push_data,
  input  logic [NUM_CH-1:0]           pop,
  output logic [NUM_CH-1:0]           pndng,
  output logic [NUM_CH*PAKG_SIZE-1:0] data_out,
  output logic [NUM_CH-1:0]           full,
  output logic [NUM_CH*CW-1:0]        count,
  output logic [NUM_CH*16-1:0]        drop_cnt
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

`ifndef MESH_DST_CHECK_EN
  logic w_unused_bdcst;
  assign w_unused_bdcst = ^BDCST;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PAKG_SIZE-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]        r_rd_ptr, r_wr_ptr;
    logic [PW-1:0]        w_rd_ptr_inc, w_wr_ptr_inc, w_rd_ptr_nxt, w_wr_ptr_nxt;
    logic [CW-1:0]        r_count, w_count_nxt;
    logic [15:0]          r_drop, w_drop_nxt;
    logic [PAKG_SIZE-1:0] r_head, w_head_nxt, w_din;
    logic                 r_pndng, r_full;
    logic                 w_pop_ok, w_push_ok, w_dst_ok;

    assign w_din = push_data[k*PAKG_SIZE +: PAKG_SIZE];

`ifdef MESH_DST_CHECK_EN
    logic [7:0] w_hdr_id;
    logic [3:0] w_hdr_row, w_hdr_col;
    assign w_hdr_id  = w_din[PAKG_SIZE-1  -: 8];
    assign w_hdr_row = w_din[PAKG_SIZE-9  -: 4];
    assign w_hdr_col = w_din[PAKG_SIZE-13 -: 4];
    // Broadcast bypasses the address check; unicast must land inside the mesh.
    assign w_dst_ok  = (w_hdr_id == BDCST) ||
                       ((32'(w_hdr_row) < ROWS) && (32'(w_hdr_col) < COLUMNS));
`else
    assign w_dst_ok  = 1'b1;
`endif

    // Next-state for pointers, occupancy, head register and drop counter
    always_comb begin
      w_pop_ok     = 1'b0;
      w_push_ok    = 1'b0;
      w_rd_ptr_inc = '0;
      w_wr_ptr_inc = '0;
      w_rd_ptr_nxt = r_rd_ptr;
      w_wr_ptr_nxt = r_wr_ptr;
      w_count_nxt  = r_count;
      w_head_nxt   = r_head;
      w_drop_nxt   = r_drop;

      w_pop_ok     = pop[k] && (r_count != '0);
      // A full channel still accepts a push when the same edge frees a slot
      w_push_ok    = push[k] && w_dst_ok && (!r_full || w_pop_ok);

      w_rd_ptr_inc = (r_rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
      w_wr_ptr_inc = (r_wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);

      if (w_pop_ok)  w_rd_ptr_nxt = w_rd_ptr_inc;
      if (w_push_ok) w_wr_ptr_nxt = w_wr_ptr_inc;

      unique case ({w_push_ok, w_pop_ok})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase

      // Head is registered so data_out never sees push_data combinationally
      if (w_push_ok && (r_count == '0)) begin
        w_head_nxt = w_din;
      end else if (w_pop_ok) begin
        w_head_nxt = (r_count == CW'(1)) ? w_din : r_mem[w_rd_ptr_inc];
      end

      if (push[k] && !w_push_ok && (r_drop != 16'hFFFF)) w_drop_nxt = r_drop + 16'd1;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_drop   <= '0;
        r_head   <= '0;
        r_pndng  <= 1'b0;
        r_full   <= 1'b0;
      end else begin
        r_rd_ptr <= w_rd_ptr_nxt;
        r_wr_ptr <= w_wr_ptr_nxt;
        r_count  <= w_count_nxt;
        r_drop   <= w_drop_nxt;
        r_head   <= w_head_nxt;
        r_pndng  <= (w_count_nxt != '0);
        r_full   <= (w_count_nxt == CW'(FIFO_DEPTH));
      end
    end

    // Storage array carries no reset; validity is tracked by the pointers
    always_ff @(posedge clk_i) begin
      if (!rst_i && w_push_ok) r_mem[r_wr_ptr] <= w_din;
    end

    assign pndng[k]                         = r_pndng;
    assign full[k]                          = r_full;
    assign data_out[k*PAKG_SIZE +: PAKG_SIZE] = r_head;
    assign count[k*CW +: CW]                = r_count;
    assign drop_cnt[k*16 +: 16]             = r_drop;
  end

endmodule
